// File: rtl/fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch front end.
// No logic; widths, the canonical NOP and fetch state encodings.
// Imported by fetch_unit.
package fetch_unit_pkg;

   localparam int DATA_BUS_BITS  = 64;
   localparam int INSTR_BUS_BITS = 32;

   // addi x0, x0, 0 : the bubble injected into IF/ID
   localparam logic [INSTR_BUS_BITS-1:0] INSTR_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH_REQ  = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_HOLD = 2'd2,
      FETCH_DROP = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one outstanding imem request, feeds IF/ID.
// Latency: request cycle + memory latency; deliver is combinational in the response cycle.
// Backpressure: stall_i parks a response in a one-entry skid buffer; redirect_i flushes with a NOP bubble.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [DATA_BUS_BITS-1:0] RESET_PC = '0,
   parameter int DATA_W  = DATA_BUS_BITS,
   parameter int INSTR_W = INSTR_BUS_BITS
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall_i,
   input  logic               redirect_i,
   input  logic [DATA_W-1:0]  redirect_pc_i,
   output logic               imem_req_o,
   output logic [DATA_W-1:0]  imem_addr_o,
   input  logic               imem_rvalid_i,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [DATA_W-1:0]  pc_o,
   output logic [DATA_W-1:0]  pcplus4_o,
   output logic               ifid_we_o
);

   localparam logic [INSTR_W-1:0] NOP = INSTR_W'(INSTR_NOP);

   fetch_state_e       state_q, state_d;
   logic [DATA_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] buf_q, buf_d;

   logic               req_c, we_c;
   logic [INSTR_W-1:0] instr_c;
   logic [DATA_W-1:0]  pc_c, pcplus4_c;

   logic [DATA_W-1:0]  pc_plus4;
   logic [DATA_W-1:0]  redirect_tgt;

   // Sequential wraps modulo 2^DATA_W; targets are forced word-aligned.
   assign pc_plus4     = pc_q + DATA_W'(4);
   assign redirect_tgt = {redirect_pc_i[DATA_W-1:2], 2'b00};

   // State, PC and skid buffer registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH_REQ;
         pc_q    <= RESET_PC;
         buf_q   <= NOP;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         buf_q   <= buf_d;
      end
   end

   // Next-state and IF/ID drive; redirect overrides stall and any response.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      buf_d     = buf_q;
      req_c     = 1'b0;
      we_c      = 1'b0;
      instr_c   = NOP;
      pc_c      = '0;
      pcplus4_c = '0;

      if (redirect_i) begin
         pc_d = redirect_tgt;
         we_c = 1'b1;
         case (state_q)
            // An unanswered request will still return; DROP swallows it.
            FETCH_WAIT: state_d = imem_rvalid_i ? FETCH_REQ : FETCH_DROP;
            FETCH_DROP: state_d = imem_rvalid_i ? FETCH_REQ : FETCH_DROP;
            default:    state_d = FETCH_REQ;
         endcase
      end else begin
         case (state_q)
            FETCH_REQ: begin
               req_c   = 1'b1;
               state_d = FETCH_WAIT;
            end
            FETCH_WAIT: begin
               if (imem_rvalid_i) begin
                  if (stall_i) begin
                     buf_d   = imem_rdata_i;
                     state_d = FETCH_HOLD;
                  end else begin
                     we_c      = 1'b1;
                     instr_c   = imem_rdata_i;
                     pc_c      = pc_q;
                     pcplus4_c = pc_plus4;
                     pc_d      = pc_plus4;
                     state_d   = FETCH_REQ;
                  end
               end
            end
            FETCH_HOLD: begin
               if (!stall_i) begin
                  we_c      = 1'b1;
                  instr_c   = buf_q;
                  pc_c      = pc_q;
                  pcplus4_c = pc_plus4;
                  pc_d      = pc_plus4;
                  state_d   = FETCH_REQ;
               end
            end
            FETCH_DROP: begin
               if (imem_rvalid_i) begin
                  state_d = FETCH_REQ;
               end
            end
            default: state_d = FETCH_REQ;
         endcase
      end
   end

   // Outputs held at their idle values while reset is asserted.
   assign imem_addr_o = pc_q;
   assign imem_req_o  = req_c & reset;
   assign ifid_we_o   = we_c & reset;
   assign instr_o     = reset ? instr_c   : NOP;
   assign pc_o        = reset ? pc_c      : '0;
   assign pcplus4_o   = reset ? pcplus4_c : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit: sequential fetch, stall, redirect,
// combined redirect/stall/rvalid, mid-request reset and PC wraparound.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

   logic        clk;
   logic        reset;
   logic        stall_i, redirect_i, imem_rvalid_i;
   logic [63:0] redirect_pc_i;
   logic [31:0] imem_rdata_i;
   logic        imem_req_o, ifid_we_o;
   logic [63:0] imem_addr_o, pc_o, pcplus4_o;
   logic [31:0] instr_o;

   logic        w_reset, w_rvalid;
   logic [31:0] w_rdata;
   logic        w_req, w_we;
   logic [63:0] w_addr, w_pc, w_pcp4, w_redirect_pc;
   logic [31:0] w_instr;
   logic        w_zero;

   int n_cmp;
   int n_err;

   logic [225:0] obs, obs_w, exp;

   fetch_unit #(.RESET_PC(64'h0)) dut (
      .clk           (clk),
      .reset         (reset),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .pcplus4_o     (pcplus4_o),
      .ifid_we_o     (ifid_we_o)
   );

   fetch_unit #(.RESET_PC(WRAP_PC)) dut_w (
      .clk           (clk),
      .reset         (w_reset),
      .stall_i       (w_zero),
      .redirect_i    (w_zero),
      .redirect_pc_i (w_redirect_pc),
      .imem_req_o    (w_req),
      .imem_addr_o   (w_addr),
      .imem_rvalid_i (w_rvalid),
      .imem_rdata_i  (w_rdata),
      .instr_o       (w_instr),
      .pc_o          (w_pc),
      .pcplus4_o     (w_pcp4),
      .ifid_we_o     (w_we)
   );

   assign obs   = {imem_req_o, ifid_we_o, imem_addr_o, instr_o, pc_o, pcplus4_o};
   assign obs_w = {w_req, w_we, w_addr, w_instr, w_pc, w_pcp4};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packs an expected output vector: {req, we, addr, instr, pc, pcplus4}.
   function automatic logic [225:0] vec(input logic req, input logic we, input logic [63:0] addr,
                                        input logic [31:0] ins, input logic [63:0] pc,
                                        input logic [63:0] pcp4);
      return {req, we, addr, ins, pc, pcp4};
   endfunction

   task automatic idle_inputs();
      stall_i       = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 64'h0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      @(negedge clk);
      #1;
      n_cmp++; exp = vec(1'b0, 1'b0, 64'h0, NOP, 64'h0, 64'h0);
      if (obs !== exp) begin n_err++; $display("FAIL reset_outputs got=%h want=%h", obs, exp); end
      // A redirect while in reset must not leak a write enable.
      redirect_i = 1'b1; redirect_pc_i = 64'h40; #1;
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL reset_redirect got=%h want=%h", obs, exp); end
      redirect_i = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_sequential();
      logic [31:0] words [3];
      words[0] = 32'hAAAA_0001; words[1] = 32'hBBBB_0002; words[2] = 32'hCCCC_0003;
      for (int i = 0; i < 3; i++) begin
         imem_rvalid_i = 1'b0; #1;
         n_cmp++; exp = vec(1'b1, 1'b0, 64'(i*4), NOP, 64'h0, 64'h0);
         if (obs !== exp) begin n_err++; $display("FAIL seq_req%0d got=%h want=%h", i, obs, exp); end
         @(negedge clk);
         imem_rvalid_i = 1'b1; imem_rdata_i = words[i]; #1;
         n_cmp++; exp = vec(1'b0, 1'b1, 64'(i*4), words[i], 64'(i*4), 64'(i*4+4));
         if (obs !== exp) begin n_err++; $display("FAIL seq_deliver%0d got=%h want=%h", i, obs, exp); end
         @(negedge clk);
      end
      imem_rvalid_i = 1'b0;
   endtask

   task automatic test_stall();
      // Fetch at 0xC to bring the PC to 0x10.
      #1; n_cmp++; exp = vec(1'b1, 1'b0, 64'hC, NOP, 64'h0, 64'h0);
      if (obs !== exp) begin n_err++; $display("FAIL stall_pre_req got=%h want=%h", obs, exp); end
      @(negedge clk);
      imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1234_5678; #1;
      @(negedge clk);
      imem_rvalid_i = 1'b0; #1;
      n_cmp++; exp = vec(1'b1, 1'b0, 64'h10, NOP, 64'h0, 64'h0);
      if (obs !== exp) begin n_err++; $display("FAIL stall_req10 got=%h want=%h", obs, exp); end
      @(negedge clk);
      stall_i = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0050_0093; #1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; exp = vec(1'b0, 1'b0, 64'h10, NOP, 64'h0, 64'h0);
         if (obs !== exp) begin n_err++; $display("FAIL stall_hold%0d got=%h want=%h", i, obs, exp); end
         @(negedge clk);
         imem_rvalid_i = 1'b0; imem_rdata_i = 32'hFFFF_FFFF; #1;
      end
      stall_i = 1'b0; #1;
      n_cmp++; exp = vec(1'b0, 1'b1, 64'h10, 32'h0050_0093, 64'h10, 64'h14);
      if (obs !== exp) begin n_err++; $display("FAIL stall_release got=%h want=%h", obs, exp); end
      @(negedge clk);
      #1; n_cmp++; exp = vec(1'b1, 1'b0, 64'h14, NOP, 64'h0, 64'h0);
      if (obs !== exp) begin n_err++; $display("FAIL stall_next_req got=%h want=%h", obs, exp); end
      @(negedge clk);
   endtask

   task automatic test_redirect_wait();
      // Request at 0x14 went out last cycle; memory answers 3 cycles after it.
      #1; n_cmp++; exp = vec(1'b0, 1'b0, 64'h14, NOP, 64'h0, 64'h0);
      if (obs !== exp) begin n_err++; $display("FAIL redir_wait1 got=%h want=%h", obs, exp); end
      @(negedge clk);
      redirect_i = 1'b1; redirect_pc_i = 64'h103; #1;
      n_cmp++; exp = vec(1'b0, 1'b1, 64'h14, NOP, 64'h0, 64'h0);
      if (obs !== exp) begin n_err++; $display("FAIL redir_bubble got=%h want=%h", obs, exp); end
      @(negedge clk);
      redirect_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_0014; #1;
      n_cmp++; exp = vec(1'b0, 1'b0, 64'h100, NOP, 64'h0, 64'h0);
      if (obs !== exp) begin n_err++; $display("FAIL redir_stale_drop got=%h want=%h", obs, exp); end
      @(negedge clk);
      imem_rvalid_i = 1'b0; #1;
      n_cmp++; exp = vec(1'b1, 1'b0, 64'h100, NOP, 64'h0, 64'h0);
      if (obs !== exp) begin n_err++; $display("FAIL redir_new_req got=%h want=%h", obs, exp); end
      @(negedge clk);
   endtask

   task automatic test_redirect_stall_rvalid();
      redirect_i = 1'b1; stall_i = 1'b1; imem_rvalid_i = 1'b1;
      imem_rdata_i = 32'hBAD0_BAD0; redirect_pc_i = 64'h2001; #1;
      n_cmp++; exp = vec(1'b0, 1'b1, 64'h100, NOP, 64'h0, 64'h0);
      if (obs !== exp) begin n_err++; $display("FAIL combo_bubble got=%h want=%h", obs, exp); end
      @(negedge clk);
      idle_inputs(); #1;
      n_cmp++; exp = vec(1'b1, 1'b0, 64'h2000, NOP, 64'h0, 64'h0);
      if (obs !== exp) begin n_err++; $display("FAIL combo_target_req got=%h want=%h", obs, exp); end
      @(negedge clk);
      imem_rvalid_i = 1'b1; imem_rdata_i = 32'hEEEE_2000; #1;
      n_cmp++; exp = vec(1'b0, 1'b1, 64'h2000, 32'hEEEE_2000, 64'h2000, 64'h2004);
      if (obs !== exp) begin n_err++; $display("FAIL combo_deliver got=%h want=%h", obs, exp); end
      @(negedge clk);
      // Redirect while in REQ: no request this cycle, new PC next cycle.
      imem_rvalid_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 64'h302; #1;
      n_cmp++; exp = vec(1'b0, 1'b1, 64'h2004, NOP, 64'h0, 64'h0);
      if (obs !== exp) begin n_err++; $display("FAIL req_redirect got=%h want=%h", obs, exp); end
      @(negedge clk);
      idle_inputs(); #1;
      n_cmp++; exp = vec(1'b1, 1'b0, 64'h300, NOP, 64'h0, 64'h0);
      if (obs !== exp) begin n_err++; $display("FAIL req_redirect_next got=%h want=%h", obs, exp); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_request();
      // DUT is in WAIT for 0x300.
      reset = 1'b0; #1;
      n_cmp++; exp = vec(1'b0, 1'b0, 64'h0, NOP, 64'h0, 64'h0);
      if (obs !== exp) begin n_err++; $display("FAIL midreset_async got=%h want=%h", obs, exp); end
      @(negedge clk);
      reset = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0BAD_0300; #1;
      n_cmp++; exp = vec(1'b1, 1'b0, 64'h0, NOP, 64'h0, 64'h0);
      if (obs !== exp) begin n_err++; $display("FAIL midreset_fresh_req got=%h want=%h", obs, exp); end
      @(negedge clk);
      imem_rvalid_i = 1'b0; #1;
      n_cmp++; exp = vec(1'b0, 1'b0, 64'h0, NOP, 64'h0, 64'h0);
      if (obs !== exp) begin n_err++; $display("FAIL midreset_wait got=%h want=%h", obs, exp); end
      @(negedge clk);
      imem_rvalid_i = 1'b1; imem_rdata_i = 32'hF00D_0000; #1;
      n_cmp++; exp = vec(1'b0, 1'b1, 64'h0, 32'hF00D_0000, 64'h0, 64'h4);
      if (obs !== exp) begin n_err++; $display("FAIL midreset_deliver got=%h want=%h", obs, exp); end
      @(negedge clk);
      imem_rvalid_i = 1'b0;
   endtask

   task automatic test_pc_wrap();
      #1; n_cmp++; exp = vec(1'b0, 1'b0, WRAP_PC, NOP, 64'h0, 64'h0);
      if (obs_w !== exp) begin n_err++; $display("FAIL wrap_reset got=%h want=%h", obs_w, exp); end
      @(negedge clk);
      w_reset = 1'b1; #1;
      n_cmp++; exp = vec(1'b1, 1'b0, WRAP_PC, NOP, 64'h0, 64'h0);
      if (obs_w !== exp) begin n_err++; $display("FAIL wrap_req0 got=%h want=%h", obs_w, exp); end
      @(negedge clk);
      w_rvalid = 1'b1; w_rdata = 32'h1111_FFFC; #1;
      n_cmp++; exp = vec(1'b0, 1'b1, WRAP_PC, 32'h1111_FFFC, WRAP_PC, 64'h0);
      if (obs_w !== exp) begin n_err++; $display("FAIL wrap_deliver got=%h want=%h", obs_w, exp); end
      @(negedge clk);
      w_rvalid = 1'b0; #1;
      n_cmp++; exp = vec(1'b1, 1'b0, 64'h0, NOP, 64'h0, 64'h0);
      if (obs_w !== exp) begin n_err++; $display("FAIL wrap_req1 got=%h want=%h", obs_w, exp); end
      @(negedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      w_reset = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
      w_zero = 1'b0; w_redirect_pc = 64'h0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_wait();
      test_redirect_stall_rvalid();
      test_reset_mid_request();
      test_pc_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
